// File: rtl/cnt_arb_if.sv
// cnt_arb_if: request/response and shared count-unit bundle for cnt_arb.
// master = requesters + count unit side, slave = cnt_arb.
//   Req0*/Req1*   request handshake and operands, per requester
//   Rsp0*/Rsp1*   response handshake; RspResult is shared
//   Cnt*          operand drive to the shared count unit, CntResult back
interface cnt_arb_if #(
    parameter int WIDTH = 32
);
    logic             Req0Valid;
    logic             Req1Valid;
    logic             Req0Ready;
    logic             Req1Ready;
    logic [WIDTH-1:0] Req0A;
    logic [WIDTH-1:0] Req1A;
    logic [1:0]       Req0B;
    logic [1:0]       Req1B;
    logic             Req0W64;
    logic             Req1W64;
    logic [WIDTH-1:0] CntA;
    logic [WIDTH-1:0] CntRevA;
    logic [1:0]       CntB;
    logic             CntW64;
    logic [WIDTH-1:0] CntResult;
    logic             Rsp0Valid;
    logic             Rsp1Valid;
    logic             Rsp0Ready;
    logic             Rsp1Ready;
    logic [WIDTH-1:0] RspResult;

    modport master (
        output Req0Valid, Req1Valid, Req0A, Req1A,
        output Req0B, Req1B, Req0W64, Req1W64,
        output CntResult, Rsp0Ready, Rsp1Ready,
        input  Req0Ready, Req1Ready, CntA, CntRevA,
        input  CntB, CntW64, Rsp0Valid, Rsp1Valid,
        input  RspResult
    );

    modport slave (
        input  Req0Valid, Req1Valid, Req0A, Req1A,
        input  Req0B, Req1B, Req0W64, Req1W64,
        input  CntResult, Rsp0Ready, Rsp1Ready,
        output Req0Ready, Req1Ready, CntA, CntRevA,
        output CntB, CntW64, Rsp0Valid, Rsp1Valid,
        output RspResult
    );
endinterface

// File: rtl/cnt_arb.sv
// cnt_arb: two-requester sequencer sharing one clz/ctz/cpop count unit.
// Ports: clk, reset (sync, active-high), bus (cnt_arb_if.slave).
// Define CNT_ARB_RR_EN for round-robin ties; default is Req0-first.
module cnt_arb #(
    parameter int WIDTH = 32
) (
    input  logic      clk,
    input  logic      reset,
    cnt_arb_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state;
    logic             owner;
    logic [WIDTH-1:0] op_a;
    logic [1:0]       op_b;
    logic             op_w64;
    logic [WIDTH-1:0] rsp_q;
    logic             gnt1;
    logic             any_req;
    logic             rsp_done;
    logic             accept;

`ifdef CNT_ARB_RR_EN
    logic ptr;
    // ptr names the requester that wins a tie
    assign gnt1 = bus.Req1Valid & (~bus.Req0Valid | ptr);
`else
    assign gnt1 = bus.Req1Valid & ~bus.Req0Valid;
`endif

    assign any_req  = bus.Req0Valid | bus.Req1Valid;
    assign rsp_done = (state == RESP) &
                      (owner ? bus.Rsp1Ready : bus.Rsp0Ready);
    // accept from IDLE, or in RESP once the response is consumed
    assign accept   = ~reset & any_req &
                      ((state == IDLE) | rsp_done);

    assign bus.Req0Ready = accept & ~gnt1;
    assign bus.Req1Ready = accept & gnt1;
    assign bus.Rsp0Valid = ~reset & (state == RESP) & ~owner;
    assign bus.Rsp1Valid = ~reset & (state == RESP) & owner;
    assign bus.RspResult = rsp_q;

    assign bus.CntA   = op_a;
    assign bus.CntB   = op_b;
    assign bus.CntW64 = op_w64;

    for (genvar i = 0; i < WIDTH; i++) begin : g_rev
        assign bus.CntRevA[i] = op_a[WIDTH-1-i];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            owner  <= 1'b0;
            op_a   <= '0;
            op_b   <= '0;
            op_w64 <= 1'b0;
            rsp_q  <= '0;
`ifdef CNT_ARB_RR_EN
            ptr    <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: if (accept) state <= EXEC;
                EXEC: begin
                    rsp_q <= bus.CntResult;
                    state <= RESP;
                end
                RESP: if (rsp_done) state <= accept ? EXEC : IDLE;
                default: state <= IDLE;
            endcase
            if (accept) begin
                owner  <= gnt1;
                op_a   <= gnt1 ? bus.Req1A : bus.Req0A;
                op_b   <= gnt1 ? bus.Req1B : bus.Req0B;
                // word ops only exist on RV64
                op_w64 <= (WIDTH == 64) &
                          (gnt1 ? bus.Req1W64 : bus.Req0W64);
`ifdef CNT_ARB_RR_EN
                ptr    <= ~gnt1;
`endif
            end
        end
    end
endmodule
